// File: rtl/mmio_uart_tx_if.sv
// MEM-stage data bus as seen by a memory-mapped responder.
// The master side is the CPU. The slave side decodes its own window and answers loads.
interface mmio_uart_tx_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic        Hit;
    logic [31:0] ReadData;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  Hit, ReadData
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output Hit, ReadData
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Stores to TXDATA queue bytes in a small FIFO, and a serializer drains the FIFO onto Tx.
// Loads from STATUS report the FIFO state, the serializer state and a sticky overflow flag.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_1000,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    mmio_uart_tx_if.slave      bus,
    output logic               Tx,
    output logic               IrqEmpty
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [1:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shreg;
    logic          r_tx;
    logic          r_irq;

    logic          w_hit, w_push_req, w_clr_ovf, w_push, w_pop, w_tick;
    logic          w_full, w_empty, w_busy;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_status;
    logic          w_unused;

    // Address decode: an 8-byte window, where bit 2 selects the register and bits 1:0 are don't-care.
    assign w_hit      = (bus.Address[31:3] == BASE_ADDR[31:3]);
    assign w_push_req = w_hit && bus.MemWrite && !bus.Address[2];
    assign w_clr_ovf  = w_hit && bus.MemWrite &&  bus.Address[2];

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_busy  = (r_state != S_IDLE);
    assign w_tick  = (r_baud == BW'(CLKS_PER_BIT - 1));

    // A full FIFO still accepts a byte when the serializer pops on the same edge.
    assign w_push = w_push_req && (!w_full || w_pop);

    assign w_status = {16'b0, 8'(r_count), 4'b0, r_ovf, w_full, w_empty, w_busy};

    assign bus.Hit      = w_hit;
    assign bus.ReadData = (w_hit && bus.MemRead && bus.Address[2]) ? w_status : 32'b0;
    assign Tx           = r_tx;
    assign IrqEmpty     = r_irq;

    assign w_unused = &{1'b0, bus.Address[1:0], bus.WriteData[31:8]};

    // Serializer next state and pop decision.
    // STOP chains straight into START when more data is waiting.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tick && (r_bitcnt == 3'd7)) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_tick) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Occupancy after this edge. A simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage, left unreset because reset discards contents through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.WriteData[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow. Pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= w_count_nxt;
            if (w_push_req && !w_push) r_ovf <= 1'b1;
            else if (w_clr_ovf)        r_ovf <= 1'b0;
        end
    end

    // Serializer state, baud divider, bit index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitcnt <= 3'd0;
            r_shreg  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) r_baud <= '0;
            else                   r_baud <= w_tick ? '0 : r_baud + BW'(1);
            if (w_tick && (r_state == S_START))     r_bitcnt <= 3'd0;
            else if (w_tick && (r_state == S_DATA)) r_bitcnt <= r_bitcnt + 3'd1;
            if (w_pop) r_shreg <= r_mem[r_rptr];
        end
    end

    // Registered line driver: Tx follows the current state one cycle later, LSB first in DATA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shreg[r_bitcnt];
                default: r_tx <= 1'b1;
            endcase
        end
    end

    // Empty interrupt, taken from the state that will hold after this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_irq <= 1'b1;
        else       r_irq <= (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx.
// Inputs are driven and outputs sampled on the falling edge.
// Frames are checked mid-bit against hand-computed 8N1 waveforms.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h1001_1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic Tx, IrqEmpty;
    logic [31:0] rd;
    logic        h;
    logic        ok;
    logic [7:0]  bv [5] = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h5A};
    int n_chk = 0;
    int n_pass = 0;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .Tx       (Tx),
        .IrqEmpty (IrqEmpty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    // Drive a store for exactly one rising edge. Call at a falling edge; returns at the next one.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.Address   = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        @(negedge clk);
        bus.MemWrite  = 1'b0;
    endtask

    // Combinational load: no clock edge is consumed.
    task automatic load(input logic [31:0] a, output logic [31:0] d, output logic hit);
        bus.Address = a;
        bus.MemRead = 1'b1;
        #1;
        d   = bus.ReadData;
        hit = bus.Hit;
        bus.MemRead = 1'b0;
    endtask

    // lead = falling edges until mid start bit. Returns at the last cycle of the stop bit.
    task automatic check_frame(input logic [7:0] b, input int lead);
        repeat (lead) @(negedge clk);
        chk("start_bit", Tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            chk($sformatf("data_bit%0d", i), Tx, b[i]);
        end
        repeat (16) @(negedge clk);
        chk("stop_bit", Tx, 1'b1);
        repeat (7) @(negedge clk);
        chk("stop_end", Tx, 1'b1);
    endtask

    initial begin
        bus.Address = 32'h0; bus.WriteData = 32'h0;
        bus.MemWrite = 1'b0; bus.MemRead = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", Tx, 1'b1);
        chk("rst_irq", IrqEmpty, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        load(BASE + 4, rd, h);
        chk("status_idle", rd, 32'h0000_0002);
        chk("hit_status", h, 1'b1);

        // single byte: latency, frame shape and end-of-frame interrupt
        store(BASE, 32'hFFFF_FFA5);
        @(negedge clk);
        chk("lat_pre", Tx, 1'b1);
        chk("irq_busy", IrqEmpty, 1'b0);
        @(negedge clk);
        chk("lat_low", Tx, 1'b0);
        check_frame(8'hA5, 8);
        @(negedge clk);
        chk("end_irq", IrqEmpty, 1'b1);
        chk("end_tx", Tx, 1'b1);

        // five back-to-back stores fill the FIFO behind the first pop
        for (int i = 0; i < 5; i++) store(BASE, {24'h0, bv[i]});
        load(BASE + 4, rd, h);
        chk("status_full", rd, 32'h0000_0405);
        store(BASE, 32'h0000_0077);
        load(BASE + 4, rd, h);
        chk("status_ovf", rd, 32'h0000_040D);
        store(BASE + 4, 32'hFFFF_FFFF);
        load(BASE + 4, rd, h);
        chk("status_ovf_clr", rd, 32'h0000_0405);
        check_frame(bv[0], 4);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("no_gap", Tx, 1'b0);
            check_frame(bv[i], 8);
        end
        @(negedge clk);
        chk("burst_irq", IrqEmpty, 1'b1);
        load(BASE + 4, rd, h);
        chk("burst_status", rd, 32'h0000_0002);

        // register map corners and accesses outside the window
        load(BASE, rd, h);
        chk("txdata_read", rd, 32'h0);
        load(BASE + 7, rd, h);
        chk("status_alias", rd, 32'h0000_0002);
        load(BASE + 8, rd, h);
        chk("hit_above", h, 1'b0);
        chk("rd_above", rd, 32'h0);
        load(BASE - 4, rd, h);
        chk("hit_below", h, 1'b0);
        chk("rd_below", rd, 32'h0);
        store(BASE + 8, 32'h55);
        store(BASE - 4, 32'h55);
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (Tx !== 1'b1 || IrqEmpty !== 1'b1) ok = 1'b0;
        end
        chk("unmapped_idle", ok, 1'b1);
        load(BASE + 4, rd, h);
        chk("unmapped_status", rd, 32'h0000_0002);

        // reset in the middle of a frame, with more bytes still queued
        store(BASE, 32'h00);
        store(BASE, 32'h00);
        store(BASE, 32'h12);
        repeat (50) @(negedge clk);
        chk("pre_rst_tx", Tx, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_tx", Tx, 1'b1);
        chk("rst_mid_irq", IrqEmpty, 1'b1);
        load(BASE + 4, rd, h);
        chk("rst_mid_status", rd, 32'h0000_0002);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (Tx !== 1'b1 || IrqEmpty !== 1'b1) ok = 1'b0;
        end
        chk("post_rst_idle", ok, 1'b1);
        load(BASE + 4, rd, h);
        chk("post_rst_status", rd, 32'h0000_0002);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
